// File: rtl/fifo_write_arbiter_if.sv
// Handshake bundle between NUM_REQ producers, the write arbiter and one FIFO write port.
// The producer/FIFO side drives through master; the arbiter connects through slave.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int WORD_LENGTH = 8,
    parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]             i_req_valid;
    logic [NUM_REQ*WORD_LENGTH-1:0] i_req_data;
    logic [NUM_REQ-1:0]             o_req_ready;
    logic                           i_fifo_full;
    logic                           o_fifo_write_en;
    logic [WORD_LENGTH-1:0]         o_fifo_data;
    logic                           o_grant_valid;
    logic [ID_W-1:0]                o_grant_id;

    modport master (
        output i_req_valid, i_req_data, i_fifo_full,
        input  o_req_ready, o_fifo_write_en, o_fifo_data, o_grant_valid, o_grant_id
    );

    modport slave (
        input  i_req_valid, i_req_data, i_fifo_full,
        output o_req_ready, o_fifo_write_en, o_fifo_data, o_grant_valid, o_grant_id
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among NUM_REQ producers.
// Grant and data are combinational from state, so words move at one per cycle with no bubbles.
module fifo_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WORD_LENGTH = 8,
    parameter int MAX_BURST   = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    fifo_write_arbiter_if.slave bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  last_owner_q, last_owner_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic             found;
    logic             locked_grant;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  cand;
    logic             grant_valid;
    logic             transfer;

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= UNLOCKED;
            last_owner_q <= ID_W'(NUM_REQ - 1);
            owner_q      <= '0;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        found        = 1'b0;
        locked_grant = 1'b0;
        grant_id     = '0;
        cand         = '0;
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        burst_cnt_d  = burst_cnt_q;
        bus.o_req_ready = '0;
        bus.o_fifo_data = '0;

        if (state_q == LOCKED && bus.i_req_valid[owner_q] &&
            burst_cnt_q < CNT_W'(MAX_BURST)) begin
            found        = 1'b1;
            locked_grant = 1'b1;
            grant_id     = owner_q;
        end else begin
            // last_owner itself is the final candidate, giving everyone else priority.
            for (int i = 1; i <= NUM_REQ; i++) begin
                cand = ID_W'((int'(last_owner_q) + i) % NUM_REQ);
                if (!found && bus.i_req_valid[cand]) begin
                    found    = 1'b1;
                    grant_id = cand;
                end
            end
        end

        grant_valid = found & ~i_reset;
        transfer    = grant_valid & ~bus.i_fifo_full;

        bus.o_grant_valid   = grant_valid;
        bus.o_grant_id      = grant_valid ? grant_id : '0;
        bus.o_fifo_write_en = transfer;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_valid && grant_id == ID_W'(k)) begin
                bus.o_req_ready[k] = transfer;
                bus.o_fifo_data    = bus.i_req_data[k*WORD_LENGTH +: WORD_LENGTH];
            end
        end

        // An owner that drops valid gives up the lock at once; a new grant below may override.
        if (state_q == LOCKED && !bus.i_req_valid[owner_q]) begin
            state_d      = UNLOCKED;
            last_owner_d = owner_q;
            burst_cnt_d  = '0;
        end

        if (transfer) begin
            if (locked_grant) begin
                burst_cnt_d = burst_cnt_q + 1'b1;
                if (burst_cnt_d == CNT_W'(MAX_BURST)) begin
                    state_d      = UNLOCKED;
                    last_owner_d = owner_q;
                end
            end else begin
                owner_d     = grant_id;
                burst_cnt_d = CNT_W'(1);
                if (MAX_BURST == 1) begin
                    state_d      = UNLOCKED;
                    last_owner_d = grant_id;
                end else begin
                    state_d = LOCKED;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: one instance with MAX_BURST=4, one with MAX_BURST=1.
// Producer k always offers word 8'hA0+k, so the expected data follows from the expected grant.
module tb_fifo_write_arbiter;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    fifo_write_arbiter_if #(.NUM_REQ(N), .WORD_LENGTH(W), .ID_W(IDW)) bus4 ();
    fifo_write_arbiter_if #(.NUM_REQ(N), .WORD_LENGTH(W), .ID_W(IDW)) bus1 ();

    fifo_write_arbiter #(.NUM_REQ(N), .WORD_LENGTH(W), .MAX_BURST(4)) dut4 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus4.slave)
    );

    fifo_write_arbiter #(.NUM_REQ(N), .WORD_LENGTH(W), .MAX_BURST(1)) dut1 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus1.slave)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [N-1:0] valid, input logic full);
        bus4.i_req_valid = valid;
        bus4.i_fifo_full = full;
        bus1.i_req_valid = valid;
        bus1.i_fifo_full = full;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive('0, 1'b0);
        next_cycle();
        rst = 1'b0;
    endtask

    // Expected {write_en, grant_valid, grant_id, ready, data}.
    function automatic logic [15:0] expv(input bit we, input bit gv, input int id);
        logic [3:0] rdy;
        logic [7:0] d;
        rdy = we ? 4'(1 << id) : 4'b0000;
        d   = gv ? 8'(8'hA0 + id) : 8'h00;
        return {we, gv, 2'(id), rdy, d};
    endfunction

    function automatic logic [15:0] obs4();
        return {bus4.o_fifo_write_en, bus4.o_grant_valid, bus4.o_grant_id,
                bus4.o_req_ready, bus4.o_fifo_data};
    endfunction

    function automatic logic [15:0] obs1();
        return {bus1.o_fifo_write_en, bus1.o_grant_valid, bus1.o_grant_id,
                bus1.o_req_ready, bus1.o_fifo_data};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b1111, 1'b0);
        #2;
        n_cmp++;
        if (obs4() !== expv(0, 0, 0)) begin
            n_err++;
            $display("FAIL reset_outputs_b4: got %h want %h", obs4(), expv(0, 0, 0));
        end
        n_cmp++;
        if (obs1() !== expv(0, 0, 0)) begin
            n_err++;
            $display("FAIL reset_outputs_b1: got %h want %h", obs1(), expv(0, 0, 0));
        end
        next_cycle();
        rst = 1'b0;
        #2;
        n_cmp++;
        if (obs4() !== expv(1, 1, 0)) begin
            n_err++;
            $display("FAIL reset_first_grant: got %h want %h", obs4(), expv(1, 1, 0));
        end
    endtask

    task automatic test_round_robin_burst();
        int ids [17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
        apply_reset();
        drive(4'b1111, 1'b0);
        for (int i = 0; i < 17; i++) begin
            #2;
            n_cmp++;
            if (obs4() !== expv(1, 1, ids[i])) begin
                n_err++;
                $display("FAIL round_robin cyc %0d: got %h want %h", i, obs4(), expv(1, 1, ids[i]));
            end
            next_cycle();
        end
    endtask

    task automatic test_lone_producer();
        apply_reset();
        drive(4'b0100, 1'b0);
        for (int i = 0; i < 10; i++) begin
            #2;
            n_cmp++;
            if (obs4() !== expv(1, 1, 2)) begin
                n_err++;
                $display("FAIL lone_producer cyc %0d: got %h want %h", i, obs4(), expv(1, 1, 2));
            end
            next_cycle();
        end
    endtask

    task automatic test_full_stall();
        bit full_seq [8] = '{0, 0, 1, 1, 1, 0, 0, 0};
        int ids      [8] = '{1, 1, 1, 1, 1, 1, 1, 2};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(4'b0110, full_seq[i]);
            #2;
            n_cmp++;
            if (obs4() !== expv(!full_seq[i], 1, ids[i])) begin
                n_err++;
                $display("FAIL full_stall cyc %0d: got %h want %h",
                         i, obs4(), expv(!full_seq[i], 1, ids[i]));
            end
            next_cycle();
        end
    endtask

    task automatic test_valid_drop();
        logic [3:0] vseq [7] = '{4'b1001, 4'b1001, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b1001};
        int         ids  [7] = '{0, 0, 3, 3, 3, 3, 0};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive(vseq[i], 1'b0);
            #2;
            n_cmp++;
            if (obs4() !== expv(1, 1, ids[i])) begin
                n_err++;
                $display("FAIL valid_drop cyc %0d: got %h want %h", i, obs4(), expv(1, 1, ids[i]));
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        drive(4'b0100, 1'b0);
        next_cycle();
        next_cycle();
        drive(4'b1111, 1'b0);
        #2;
        n_cmp++;
        if (obs4() !== expv(1, 1, 2)) begin
            n_err++;
            $display("FAIL mid_burst_owner: got %h want %h", obs4(), expv(1, 1, 2));
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs4() !== expv(0, 0, 0)) begin
            n_err++;
            $display("FAIL async_reset_outputs: got %h want %h", obs4(), expv(0, 0, 0));
        end
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            n_cmp++;
            if (obs4() !== expv(1, 1, 0)) begin
                n_err++;
                $display("FAIL post_reset_grant cyc %0d: got %h want %h", i, obs4(), expv(1, 1, 0));
            end
            next_cycle();
        end
    endtask

    task automatic test_pure_round_robin();
        int ids_all  [6] = '{0, 1, 2, 3, 0, 1};
        int ids_mask [4] = '{1, 3, 1, 3};
        apply_reset();
        drive(4'b1111, 1'b0);
        for (int i = 0; i < 6; i++) begin
            #2;
            n_cmp++;
            if (obs1() !== expv(1, 1, ids_all[i])) begin
                n_err++;
                $display("FAIL burst1_all cyc %0d: got %h want %h", i, obs1(), expv(1, 1, ids_all[i]));
            end
            next_cycle();
        end
        apply_reset();
        drive(4'b1010, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #2;
            n_cmp++;
            if (obs1() !== expv(1, 1, ids_mask[i])) begin
                n_err++;
                $display("FAIL burst1_mask cyc %0d: got %h want %h", i, obs1(), expv(1, 1, ids_mask[i]));
            end
            next_cycle();
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            bus4.i_req_data[k*W +: W] = 8'(8'hA0 + k);
            bus1.i_req_data[k*W +: W] = 8'(8'hA0 + k);
        end
        drive('0, 1'b0);
        #1;
        test_reset();
        test_round_robin_burst();
        test_lone_producer();
        test_full_stall();
        test_valid_drop();
        test_reset_mid_burst();
        test_pure_round_robin();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
